uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: circular buffer with show-ahead output,
// level/full/empty status and sticky overrun. Define UART_RX_FIFO_BREAK_FLUSH_EN to flush on BREAK.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_break,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic                     overrun,
   input  logic                     overrun_clear,
   output logic                     break_det
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic             overrun_reg, overrun_next;
   logic             break_det_reg, break_det_next;
   logic             pop, push, drop, flush;

`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
   assign flush = in_valid & in_break;
`else
   logic break_unused;
   assign break_unused = in_break;
   assign flush        = 1'b0;
`endif

   // Pointers carry a wrap bit, so the plain difference is the occupancy 0..DEPTH.
   assign level     = wr_ptr_reg - rd_ptr_reg;
   assign full      = (level == PW'(DEPTH));
   assign empty     = (level == '0);
   assign out_valid = !empty;
   assign out_data  = out_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;
   assign overrun   = overrun_reg;
   assign break_det = break_det_reg;

   // A pop in the same cycle frees a slot, so a full buffer still accepts the byte.
   assign pop  = out_valid & out_ready;
   assign push = in_valid & !flush & (!full | pop);
   assign drop = in_valid & !flush & full & !pop;

   always_comb begin
      wr_ptr_next    = wr_ptr_reg + PW'(push);
      rd_ptr_next    = rd_ptr_reg + PW'(pop);
      overrun_next   = overrun_reg;
      break_det_next = flush;
      if (flush) begin
         rd_ptr_next = wr_ptr_reg;
      end
      if (drop) begin
         overrun_next = 1'b1;
      end else if (overrun_clear) begin
         overrun_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         overrun_reg   <= 1'b0;
         break_det_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         overrun_reg   <= overrun_next;
         break_det_reg <= break_det_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= in_data;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_break = 1'b0;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready = 1'b0;
   logic [4:0]       level;
   logic             full, empty, overrun;
   logic             overrun_clear = 1'b0;
   logic             break_det;

   uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_break(in_break),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .level(level), .full(full), .empty(empty),
      .overrun(overrun), .overrun_clear(overrun_clear), .break_det(break_det)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int failed   = 0;

   // Reference model: the buffer is just a queue of bytes.
   logic [7:0] q[$];
   logic       mdl_ovr = 1'b0;
   logic       mdl_brk = 1'b0;

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       rdy;
      logic [4:0] lvl;
      logic       vld;
      logic [7:0] dat;
   } vec_t;
   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("m_valid",   32'(out_valid), 32'(q.size() != 0));
      chk("m_level",   32'(level),     32'(q.size()));
      chk("m_full",    32'(full),      32'(q.size() == DEPTH));
      chk("m_empty",   32'(empty),     32'(q.size() == 0));
      chk("m_overrun", 32'(overrun),   32'(mdl_ovr));
      chk("m_break",   32'(break_det), 32'(mdl_brk));
      if (q.size() != 0) chk("m_data", 32'(out_data), 32'(q[0]));
   endtask

   task automatic step(input logic iv, input logic [7:0] d, input logic b,
                       input logic rdy, input logic clr, input logic rst);
      logic pop_m, was_full, dropped, flush_m;
      in_valid = iv; in_data = d; in_break = b;
      out_ready = rdy; overrun_clear = clr; reset = rst;
      @(posedge clk);
      if (rst) begin
         q.delete(); mdl_ovr = 1'b0; mdl_brk = 1'b0;
      end else begin
         pop_m    = (q.size() > 0) && rdy;
         was_full = (q.size() == DEPTH);
         dropped  = 1'b0;
         flush_m  = 1'b0;
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
         flush_m  = iv && b;
`endif
         mdl_brk = flush_m;
         if (flush_m) begin
            q.delete();
         end else begin
            if (pop_m) void'(q.pop_front());
            if (iv) begin
               if (!was_full || pop_m) q.push_back(d);
               else dropped = 1'b1;
            end
         end
         if (dropped) mdl_ovr = 1'b1;
         else if (clr) mdl_ovr = 1'b0;
      end
      #1;
      $display("t=%0t iv=%0b d=%02h brk=%0b rdy=%0b clr=%0b rst=%0b -> lvl=%0d vld=%0b dat=%02h ovr=%0b bdet=%0b",
               $time, iv, d, b, rdy, clr, rst, level, out_valid, out_data, overrun, break_det);
      check_model();
   endtask

   task automatic fill(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] last;

      vt[0] = '{1'b1, 8'h41, 1'b0, 5'd1, 1'b1, 8'h41};
      vt[1] = '{1'b1, 8'h42, 1'b0, 5'd2, 1'b1, 8'h41};
      vt[2] = '{1'b1, 8'h43, 1'b0, 5'd3, 1'b1, 8'h41};
      vt[3] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h42};
      vt[4] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h43};
      vt[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};

      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_break", 32'(break_det), 0);
      chk("rst_data", 32'(out_data), 0);

      for (int i = 0; i < 6; i++) begin
         step(vt[i].iv, vt[i].d, 1'b0, vt[i].rdy, 1'b0, 1'b0);
         chk("tbl_level", 32'(level), 32'(vt[i].lvl));
         chk("tbl_valid", 32'(out_valid), 32'(vt[i].vld));
         if (vt[i].vld) chk("tbl_data", 32'(out_data), 32'(vt[i].dat));
      end

      // Overrun on a full buffer; a drop in the same cycle as clear keeps it set.
      fill(8'h00, DEPTH);
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovr_full", 32'(full), 1);
      chk("ovr_set", 32'(overrun), 1);
      chk("ovr_level", 32'(level), DEPTH);
      step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovr_set_wins", 32'(overrun), 1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("ovr_readback", 32'(out_data), 32'(i));
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("ovr_drained", 32'(empty), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovr_clear", 32'(overrun), 0);

      // Push and pop together while full.
      fill(8'h60, DEPTH);
      step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("fullpp_level", 32'(level), DEPTH);
      chk("fullpp_ovr", 32'(overrun), 0);
      last = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         last = out_data;
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("fullpp_last", 32'(last), 32'h55);
      chk("fullpp_empty", 32'(empty), 1);

      // Streaming across pointer wrap with a pop every cycle.
      for (int k = 0; k < 48; k++) begin
         step(1'b1, 8'h10 + 8'(k % 16), 1'b0, 1'b1, 1'b0, 1'b0);
         chk("wrap_level", 32'(level), 1);
         chk("wrap_data", 32'(out_data), 32'(8'h10 + 8'(k % 16)));
      end
      drain();

      // BREAK byte with five bytes held.
      fill(8'h30, 5);
      step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
      chk("brk_level", 32'(level), 0);
      chk("brk_pulse", 32'(break_det), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("brk_pulse_end", 32'(break_det), 0);
`else
      chk("brk_level", 32'(level), 6);
      chk("brk_det_tied", 32'(break_det), 0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("brk_last", 32'(out_data), 0);
      chk("brk_last_valid", 32'(out_valid), 1);
`endif
      drain();

      // Reset mid-operation with level 7 and overrun set.
      fill(8'h20, DEPTH);
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_level", 32'(level), 7);
      chk("pre_rst_ovr", 32'(overrun), 1);
      step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      chk("mid_rst_full", 32'(full), 0);
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_ovr", 32'(overrun), 0);
      chk("mid_rst_break", 32'(break_det), 0);
      chk("mid_rst_data", 32'(out_data), 0);

      // Random traffic, alternating slow and fast consumer phases.
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 99) < 60,
              8'($urandom),
              $urandom_range(0, 49) == 0,
              $urandom_range(0, 99) < (((n / 200) % 2 == 1) ? 80 : 25),
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 499) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
